// File: rtl/mskaes_rcon_seq.sv
// Masked AES round-constant sequencer: forward/inverse rcon walk per key size.
// Optional sticky misuse flag on port err when MSKAES_RCON_SEQ_ERR_EN is defined.
module mskaes_rcon_seq #(
    parameter int d = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic           inverse,
    input  logic           update,
    input  logic           mask_rcon,
    output logic [8*d-1:0] sh_rcon,
    output logic [3:0]     rcon_idx,
    output logic           last,
`ifdef MSKAES_RCON_SEQ_ERR_EN
    output logic           err,
`endif
    output logic           busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_nx;
    logic [3:0] idx, idx_nx;
    logic [7:0] rc, rc_nx;
    logic [1:0] mode_q, mode_nx;
    logic       inv_q, inv_nx;
    logic [3:0] last_idx;

    function automatic logic [7:0] first_rc(input logic [1:0] m, input logic inv);
        if (!inv)          return 8'h01;
        else if (m == 2'b01) return 8'h80;
        else if (m == 2'b10) return 8'h40;
        else               return 8'h36;
    endfunction

    function automatic logic [7:0] step_rc(input logic [7:0] c, input logic inv);
        if (inv) return (c == 8'h1b) ? 8'h80 : {1'b0, c[7:1]};
        else     return c[7] ? 8'h1b : {c[6:0], 1'b0};
    endfunction

    // Reserved mode 11 behaves as AES-128
    always_comb begin
        last_idx = 4'd9;
        case (mode_q)
            2'b01:   last_idx = 4'd7;
            2'b10:   last_idx = 4'd6;
            default: last_idx = 4'd9;
        endcase
    end

    assign busy     = (state == RUN);
    assign last     = busy && (idx == last_idx);
    assign rcon_idx = idx;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        rc_nx    = rc;
        mode_nx  = mode_q;
        inv_nx   = inv_q;
        if (start) begin
            state_nx = RUN;
            idx_nx   = 4'd0;
            mode_nx  = mode;
            inv_nx   = inverse;
            rc_nx    = first_rc(mode, inverse);
        end else if (update && busy) begin
            if (last) begin
                state_nx = IDLE;
            end else begin
                idx_nx = idx + 4'd1;
                rc_nx  = step_rc(rc, inv_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 4'd0;
            rc     <= 8'h00;
            mode_q <= 2'b00;
            inv_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            rc     <= rc_nx;
            mode_q <= mode_nx;
            inv_q  <= inv_nx;
        end
    end

    // Only share 0 carries the constant; the others stay zero
    always_comb begin
        sh_rcon = '0;
        for (int j = 0; j < 8; j++)
            sh_rcon[d*j] = rc[j] & mask_rcon & busy;
    end

`ifdef MSKAES_RCON_SEQ_ERR_EN
    always_ff @(posedge clk) begin
        if (rst || start)
            err <= 1'b0;
        else if (update && !busy)
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mskaes_rcon_seq.sv
// Self-checking bench for mskaes_rcon_seq: vector table, corner sequences, random run.
// Reference model indexes the AES rcon table directly; err checked when MSKAES_RCON_SEQ_ERR_EN is defined.
module tb_mskaes_rcon_seq;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           rst, start, inverse, update, mask_rcon;
    logic [1:0]     mode;
    logic [8*D-1:0] sh_rcon;
    logic [3:0]     rcon_idx;
    logic           last, busy;
`ifdef MSKAES_RCON_SEQ_ERR_EN
    logic           err;
`endif

    mskaes_rcon_seq #(.d(D)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .inverse(inverse), .update(update), .mask_rcon(mask_rcon),
        .sh_rcon(sh_rcon), .rcon_idx(rcon_idx), .last(last),
`ifdef MSKAES_RCON_SEQ_ERR_EN
        .err(err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] fwd [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    bit       m_busy = 0;
    int       m_idx = 0;
    bit [1:0] m_mode = 0;
    bit       m_inv = 0;
    bit       m_err = 0;

    function automatic int seq_len(input bit [1:0] m);
        if (m == 2'b01) return 8;
        if (m == 2'b10) return 7;
        return 10;
    endfunction

    // Inverse sequence is the forward table walked backwards from entry N-1
    function automatic logic [7:0] m_const();
        if (m_inv) return fwd[seq_len(m_mode) - 1 - m_idx];
        return fwd[m_idx];
    endfunction

    function automatic logic [7:0] share0();
        logic [7:0] s;
        for (int j = 0; j < 8; j++) s[j] = sh_rcon[D*j];
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy = 0; m_idx = 0; m_mode = 0; m_inv = 0; m_err = 0;
        end else if (start) begin
            m_busy = 1; m_idx = 0; m_mode = mode; m_inv = inverse; m_err = 0;
        end else if (update) begin
            if (!m_busy) m_err = 1;
            else if (m_idx == seq_len(m_mode) - 1) m_busy = 0;
            else m_idx++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [8*D-1:0] e;
        bit m_last;
        e = '0;
        if (m_busy && mask_rcon)
            for (int j = 0; j < 8; j++) e[D*j] = m_const()[j];
        m_last = m_busy && (m_idx == seq_len(m_mode) - 1);
        chk({tag, ".sh_rcon"}, 32'(sh_rcon), 32'(e));
        chk({tag, ".rcon_idx"}, 32'(rcon_idx), 32'(m_idx));
        chk({tag, ".last"}, 32'(last), 32'(m_last));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
`ifdef MSKAES_RCON_SEQ_ERR_EN
        chk({tag, ".err"}, 32'(err), 32'(m_err));
`endif
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit r, input bit s, input bit u,
                         input bit [1:0] m, input bit inv, input bit mk);
        rst = r; start = s; update = u; mode = m; inverse = inv; mask_rcon = mk;
    endtask

    typedef struct {
        bit [1:0]   mode;
        bit         inv;
        int         n;
        logic [7:0] first;
        logic [7:0] lastc;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{2'b00, 1'b0, 10, 8'h01, 8'h36};
        vt[1] = '{2'b00, 1'b1, 10, 8'h36, 8'h01};
        vt[2] = '{2'b10, 1'b1,  7, 8'h40, 8'h01};
        vt[3] = '{2'b01, 1'b0,  8, 8'h01, 8'h80};
        vt[4] = '{2'b01, 1'b1,  8, 8'h80, 8'h01};
        vt[5] = '{2'b10, 1'b0,  7, 8'h01, 8'h40};
        vt[6] = '{2'b11, 1'b0, 10, 8'h01, 8'h36};
        vt[7] = '{2'b11, 1'b1, 10, 8'h36, 8'h01};

        drive(1, 1, 1, 2'b10, 1, 1);
        cyc("reset");
        cyc("reset2");
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.idx", 32'(rcon_idx), 32'd0);

        foreach (vt[k]) begin
            int cnt;
            drive(0, 1, 0, vt[k].mode, vt[k].inv, 1);
            cyc("vec.start");
            chk("vec.first", 32'(share0()), 32'(vt[k].first));
            cnt = 0;
            while (!last && cnt < 12) begin
                drive(0, 0, 1, 2'($urandom), 1'($urandom), 1);
                cyc("vec.step");
                cnt++;
            end
            chk("vec.len", 32'(cnt + 1), 32'(vt[k].n));
            chk("vec.lastc", 32'(share0()), 32'(vt[k].lastc));
            cyc("vec.end");
            chk("vec.end_busy", 32'(busy), 32'd0);
            chk("vec.end_sh", 32'(sh_rcon), 32'd0);
            drive(0, 0, 0, 2'b00, 0, 1);
            cyc("vec.idle");
        end

        // Masking mid-sequence
        drive(0, 1, 0, 2'b00, 0, 1);
        cyc("mask.start");
        drive(0, 0, 1, 2'b00, 0, 1);
        repeat (3) cyc("mask.pre");
        drive(0, 0, 1, 2'b00, 0, 0);
        repeat (3) begin
            cyc("mask.off");
            chk("mask.sh_zero", 32'(sh_rcon), 32'd0);
        end
        chk("mask.idx", 32'(rcon_idx), 32'd6);
        drive(0, 0, 0, 2'b00, 0, 1);
        cyc("mask.on");
        chk("mask.val", 32'(share0()), 32'h40);

        // Reset mid-sequence with update pending
        drive(0, 1, 0, 2'b00, 1, 1);
        cyc("rst.start");
        drive(0, 0, 1, 2'b00, 1, 1);
        repeat (4) cyc("rst.step");
        chk("rst.idx4", 32'(rcon_idx), 32'd4);
        drive(1, 0, 1, 2'b00, 1, 1);
        cyc("rst.hit");
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.idx", 32'(rcon_idx), 32'd0);
        chk("rst.sh", 32'(sh_rcon), 32'd0);

        // Start and update together restarts
        drive(0, 1, 0, 2'b00, 0, 1);
        cyc("su.start");
        drive(0, 0, 1, 2'b00, 0, 1);
        repeat (3) cyc("su.step");
        drive(0, 1, 1, 2'b00, 0, 1);
        cyc("su.both");
        chk("su.idx", 32'(rcon_idx), 32'd0);
        chk("su.const", 32'(share0()), 32'h01);

        // Update while idle
        drive(1, 0, 0, 2'b00, 0, 1);
        cyc("err.rst");
        drive(0, 0, 1, 2'b00, 0, 1);
        cyc("err.set");
        drive(0, 0, 0, 2'b00, 0, 1);
        repeat (2) cyc("err.hold");
        chk("idle.busy", 32'(busy), 32'd0);
`ifdef MSKAES_RCON_SEQ_ERR_EN
        chk("err.held", 32'(err), 32'd1);
`endif
        drive(0, 1, 0, 2'b01, 0, 1);
        cyc("err.clr");
`ifdef MSKAES_RCON_SEQ_ERR_EN
        chk("err.cleared", 32'(err), 32'd0);
`endif

        // Random run
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 60), 2'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < 85));
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
